// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-in / byte-out bundle for the UART receive stage.
//   rx        : serial line into the receiver (idles high)
//   data_o    : last correctly framed byte
//   valid     : one-cycle pulse when data_o updates
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : receiver is not idle
// modport master: line driver / byte consumer side.
// modport slave : the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_o;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data_o, input valid, input frame_err, input busy);
  modport slave  (input rx, output data_o, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : uart_rx_if.slave (rx in; data_o, valid, frame_err, busy out)
// Parameter CLKS_PER_BIT (2..65535) sets the bit period in clocks.
// Optional macro UART_RX_SYNC_EN: when defined, rx passes through a 2-flop
// synchroniser (reset to 1) before all logic; when undefined, rx is used
// directly (on-chip loopback, already synchronous to clk).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_q, data_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;
  logic          rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], bus.rx};
  end

  assign rx_s = sync[1];
`else
  assign rx_s = bus.rx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = data_q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n   = S_START;
          clk_cnt_n = '0;
        end
      end

      S_START: begin
        // Re-check the line at the start-bit centre to reject glitches.
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n = '0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        // Line held low past the stop bit: wait for it to go high before
        // accepting another start bit.
        if (rx_s) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.data_o    = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT=16).
// Each frame is built as a per-clock line waveform; a reference decoder
// samples that waveform at bit centres to predict byte, stop status and
// the cycle of the result pulse.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = HALF + 9 * CPB + SYNC;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge number N, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data = 8'h00;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         f_cyc[$];
  bit         busy_log[int];
  bit         both_seen = 1'b0;

  always @(negedge clk) begin
    busy_log[cyc] = bus.busy;
    if (bus.valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(bus.data_o);
    end
    if (bus.frame_err) f_cyc.push_back(cyc);
    if (bus.valid && bus.frame_err) both_seen = 1'b1;
  end

  task automatic clear_mon();
    v_cyc.delete();
    v_dat.delete();
    f_cyc.delete();
  endtask

  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference decoder: samples the line at the centre of each bit.
  function automatic void model_frame(input bit line[$], output bit good,
                                      output logic [7:0] d, output int at);
    for (int k = 0; k < 8; k++) d[k] = line[HALF + CPB * (k + 1)];
    good = line[HALF + 9 * CPB];
    at   = LAT;
  endfunction

  // Called at a negedge; e0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles,
                            output int e0, output bit good, output logic [7:0] d,
                            output int at);
    bit line[$];
    for (int i = 0; i < CPB; i++) line.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) line.push_back(b[k]);
    for (int i = 0; i < stop_cycles; i++) line.push_back(stop_v);
    e0 = cyc + 1;
    foreach (line[i]) begin
      bus.rx = line[i];
      @(negedge clk);
    end
    model_frame(line, good, d, at);
    at = at + e0;
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 00", bus.data_o); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b want 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    rst = 1'b1;
    drive(1'b1, 4);
  endtask

  task automatic test_basic();
    int e0, at;
    bit good;
    logic [7:0] d;
    clear_mon();
    send_frame(8'hA5, 1'b1, CPB, e0, good, d, at);
    drive(1'b1, 20);
    exp_data = d;
    checks++; if (d !== 8'hA5 || !good) begin errors++; $display("FAIL basic_model got %0h want a5", d); end
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL basic_vcount got %0d want 1", v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] !== at) begin errors++; $display("FAIL basic_vcyc got %0d want %0d", v_cyc[0] - e0, at - e0); end
      checks++; if (v_dat[0] !== d) begin errors++; $display("FAIL basic_data got %0h want %0h", v_dat[0], d); end
    end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", f_cyc.size()); end
    checks++; if (busy_log[e0 + SYNC] !== 1'b1) begin errors++; $display("FAIL basic_busy_start got 0 want 1"); end
    checks++; if (busy_log[at - 1] !== 1'b1) begin errors++; $display("FAIL basic_busy_stop got 0 want 1"); end
    checks++; if (busy_log[at] !== 1'b0) begin errors++; $display("FAIL basic_busy_end got 1 want 0"); end
    checks++; if (bus.data_o !== exp_data) begin errors++; $display("FAIL basic_hold got %0h want %0h", bus.data_o, exp_data); end
  endtask

  task automatic test_glitch();
    int e0;
    clear_mon();
    e0 = cyc + 1;
    drive(1'b0, 5);
    drive(1'b1, 30);
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", v_cyc.size()); end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", f_cyc.size()); end
    checks++; if (busy_log[e0 + HALF + SYNC - 1] !== 1'b1) begin errors++; $display("FAIL glitch_busy got 0 want 1"); end
    checks++; if (busy_log[e0 + HALF + SYNC] !== 1'b0) begin errors++; $display("FAIL glitch_idle got 1 want 0"); end
    checks++; if (bus.data_o !== exp_data) begin errors++; $display("FAIL glitch_data got %0h want %0h", bus.data_o, exp_data); end
  endtask

  task automatic test_frame_err();
    int e0, at, r;
    bit good;
    logic [7:0] d;
    clear_mon();
    send_frame(8'h3C, 1'b0, CPB, e0, good, d, at);
    drive(1'b0, 40);
    r = cyc + 1;
    drive(1'b1, 20);
    checks++; if (good) begin errors++; $display("FAIL ferr_model got good want bad"); end
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", f_cyc.size()); end
    else begin
      checks++; if (f_cyc[0] !== at) begin errors++; $display("FAIL ferr_cyc got %0d want %0d", f_cyc[0] - e0, at - e0); end
    end
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", v_cyc.size()); end
    checks++; if (bus.data_o !== exp_data) begin errors++; $display("FAIL ferr_data got %0h want %0h", bus.data_o, exp_data); end
    checks++; if (busy_log[at + 30] !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got 0 want 1"); end
    checks++; if (busy_log[r + SYNC - 1] !== 1'b1) begin errors++; $display("FAIL ferr_break_hold got 0 want 1"); end
    checks++; if (busy_log[r + SYNC] !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b, ata, atb;
    bit ga, gb;
    logic [7:0] da, db;
    clear_mon();
    send_frame(8'h00, 1'b1, CPB, e0a, ga, da, ata);
    send_frame(8'hFF, 1'b1, CPB, e0b, gb, db, atb);
    drive(1'b1, 20);
    exp_data = db;
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] !== ata) begin errors++; $display("FAIL b2b_cyc0 got %0d want %0d", v_cyc[0], ata); end
      checks++; if (v_cyc[1] - v_cyc[0] !== 10 * CPB) begin errors++; $display("FAIL b2b_gap got %0d want %0d", v_cyc[1] - v_cyc[0], 10 * CPB); end
      checks++; if (v_dat[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %0h want 00", v_dat[0]); end
      checks++; if (v_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %0h want ff", v_dat[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int e0, at;
    bit good;
    logic [7:0] d;
    b = 8'h81;
    clear_mon();
    drive(1'b0, CPB);
    for (int k = 0; k < 4; k++) drive(b[k], CPB);
    drive(b[4], CPB / 2);
    rst = 1'b0;
    #1;
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL rmid_data got %0h want 00", bus.data_o); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL rmid_pulse got %0b%0b want 00", bus.valid, bus.frame_err); end
    exp_data = 8'h00;
    @(negedge clk);
    drive(1'b1, 2);
    rst = 1'b1;
    drive(1'b1, 5);
    checks++; if (v_cyc.size() !== 0 || f_cyc.size() !== 0) begin errors++; $display("FAIL rmid_nopulse got %0d want 0", v_cyc.size() + f_cyc.size()); end
    clear_mon();
    send_frame(b, 1'b1, CPB, e0, good, d, at);
    drive(1'b1, 20);
    exp_data = d;
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL rmid_vcount got %0d want 1", v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] !== at) begin errors++; $display("FAIL rmid_vcyc got %0d want %0d", v_cyc[0], at); end
      checks++; if (v_dat[0] !== 8'h81) begin errors++; $display("FAIL rmid_rxdata got %0h want 81", v_dat[0]); end
    end
  endtask

  task automatic test_random();
    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    int         ef_cyc[$];
    int e0, at, stop_cycles;
    bit good, ok;
    logic [7:0] b, d;
    clear_mon();
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      stop_cycles = ok ? CPB * $urandom_range(1, 3) : CPB + $urandom_range(0, 30);
      send_frame(b, ok, stop_cycles, e0, good, d, at);
      if (good) begin
        ev_cyc.push_back(at);
        ev_dat.push_back(d);
        exp_data = d;
      end else begin
        ef_cyc.push_back(at);
        drive(1'b1, $urandom_range(1, 20));
      end
    end
    drive(1'b1, 30);
    checks++; if (v_cyc.size() !== ev_cyc.size()) begin errors++; $display("FAIL rand_vcount got %0d want %0d", v_cyc.size(), ev_cyc.size()); end
    else begin
      foreach (ev_cyc[i]) begin
        checks++; if (v_cyc[i] !== ev_cyc[i]) begin errors++; $display("FAIL rand_vcyc[%0d] got %0d want %0d", i, v_cyc[i], ev_cyc[i]); end
        checks++; if (v_dat[i] !== ev_dat[i]) begin errors++; $display("FAIL rand_data[%0d] got %0h want %0h", i, v_dat[i], ev_dat[i]); end
      end
    end
    checks++; if (f_cyc.size() !== ef_cyc.size()) begin errors++; $display("FAIL rand_fcount got %0d want %0d", f_cyc.size(), ef_cyc.size()); end
    else begin
      foreach (ef_cyc[i]) begin
        checks++; if (f_cyc[i] !== ef_cyc[i]) begin errors++; $display("FAIL rand_fcyc[%0d] got %0d want %0d", i, f_cyc[i], ef_cyc[i]); end
      end
    end
    checks++; if (bus.data_o !== exp_data) begin errors++; $display("FAIL rand_hold got %0h want %0h", bus.data_o, exp_data); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL exclusive_pulses got 1 want 0"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
